// File: rtl/gc_req_sequencer.sv
// gc_req_sequencer
// Host-side request sequencer for the GC-DRAM. Host commands are buffered in a
// small FIFO and issued one per cycle onto the memory write/read pins. A read
// of the address most recently written is held back until WR_GAP cycles have
// passed since that write. Read data returning on rd is tagged with a
// response strobe and the original address RD_LAT cycles after re.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready, cmd_we, cmd_addr, cmd_wdata   host command handshake
//   we, re, waddr, raddr, data_in                  memory command pins
//   rd                                             memory read data
//   rsp_valid, rsp_data, rsp_addr                  read response strobe
module gc_req_sequencer #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 2,
    parameter int WR_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [9:0]  cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        we,
    output logic        re,
    output logic [9:0]  waddr,
    output logic [9:0]  raddr,
    output logic [63:0] data_in,
    input  logic [63:0] rd,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [9:0]  rsp_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_HAZARD = 2'd2;

    // Command FIFO storage (data only, no reset needed)
    logic        fifo_we   [DEPTH];
    logic [9:0]  fifo_addr [DEPTH];
    logic [63:0] fifo_data [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;
    logic [1:0]    state, state_next;
    logic [GW-1:0] gap_cnt;
    logic [9:0]    last_waddr;

    logic          push, pop, hazard;
    logic          head_we;
    logic [9:0]    head_addr;
    logic [63:0]   head_data;

    logic          pipe_v [RD_LAT];
    logic [9:0]    pipe_a [RD_LAT];

    assign cmd_ready = (count != (PW + 1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    assign head_we   = fifo_we[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign hazard = !head_we && (head_addr == last_waddr) && (gap_cnt != '0);

    // IDLE issues straight away when a command has just landed so that a
    // command accepted into an empty FIFO appears on the pins one cycle later.
    assign pop = (state != S_HAZARD) && (count != '0) && !hazard;

    assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ISSUE: begin
                if (count == '0)
                    state_next = S_IDLE;
                else if (hazard)
                    state_next = S_HAZARD;
                else if (count_next == '0)
                    state_next = S_IDLE;
                else
                    state_next = S_ISSUE;
            end
            S_HAZARD: begin
                // gap_cnt reaches 0 at this edge
                if (gap_cnt <= GW'(1))
                    state_next = S_ISSUE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]   <= cmd_we;
            fifo_addr[wr_ptr] <= cmd_addr;
            fifo_data[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_IDLE;
            gap_cnt    <= '0;
            last_waddr <= '0;
            we         <= 1'b0;
            re         <= 1'b0;
            waddr      <= '0;
            raddr      <= '0;
            data_in    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            we <= pop && head_we;
            re <= pop && !head_we;
            if (pop && head_we) begin
                waddr   <= head_addr;
                data_in <= head_data;
            end
            if (pop && !head_we)
                raddr <= head_addr;

            if (pop && head_we) begin
                last_waddr <= head_addr;
                gap_cnt    <= GW'(WR_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    // Read return pipe is fed from the registered re so the tail lines up
    // with rd exactly RD_LAT cycles after re was high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= re;
            pipe_a[0] <= raddr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign rsp_valid = pipe_v[RD_LAT-1];
    assign rsp_addr  = pipe_a[RD_LAT-1];
    assign rsp_data  = rd;

endmodule

// File: tb/tb_gc_req_sequencer.sv
module tb_gc_req_sequencer;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;
    localparam int WR_GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [9:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic        we, re;
    logic [9:0]  waddr, raddr;
    logic [63:0] data_in, rd;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [9:0]  rsp_addr;

    gc_req_sequencer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_GAP(WR_GAP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .we(we), .re(re), .waddr(waddr), .raddr(raddr), .data_in(data_in),
        .rd(rd), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [63:0] d;
        int          exp_cyc;
    } iss_t;

    typedef struct {
        logic [9:0]  a;
        logic [63:0] d;
    } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    int   rd_iss_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_seen = 0;
    bit saw_full = 0;
    bit have_w = 0;
    int last_w_cyc = 0;
    logic [9:0] last_w_addr = '0;

    logic [63:0] mem_tb  [1024];
    logic [63:0] mem_ref [1024];
    logic [63:0] rdq [RD_LAT];

    function automatic logic [63:0] init_val(input int a);
        return 64'h0000_0000_0000_1234 + (64'(a) << 16);
    endfunction

    task automatic fail(input string name, input string msg);
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: rd presents the word read RD_LAT cycles after re.
    always @(posedge clk) begin
        rdq[0] <= mem_tb[raddr];
        for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
        if (we) mem_tb[waddr] <= data_in;
    end
    assign rd = rdq[RD_LAT-1];

    // Monitor / scoreboard
    iss_t m_e;
    rsp_t m_r;
    int   m_ic;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (cmd_ready === 1'b0) saw_full = 1;
            if (we && re) begin
                checks++;
                fail("we_re_excl", "we and re both high");
            end
            if (we || re) begin
                checks++;
                if (exp_iss.size() == 0) begin
                    fail("issue_unexpected", $sformatf("got we=%0b re=%0b, want no issue", we, re));
                end else begin
                    m_e = exp_iss.pop_front();
                    if (m_e.w !== we || (we && (waddr !== m_e.a || data_in !== m_e.d)) ||
                        (re && raddr !== m_e.a))
                        fail("issue", $sformatf("got we=%0b waddr=%h raddr=%h data=%h, want we=%0b addr=%h data=%h",
                             we, waddr, raddr, data_in, m_e.w, m_e.a, m_e.d));
                    if (m_e.exp_cyc >= 0) begin
                        checks++;
                        if (cyc != m_e.exp_cyc)
                            fail("issue_cycle", $sformatf("got cycle %0d, want %0d", cyc, m_e.exp_cyc));
                    end
                end
                if (re) begin
                    rd_iss_cyc.push_back(cyc);
                    if (WR_GAP != 0 && have_w && raddr == last_w_addr) begin
                        checks++;
                        if (cyc < last_w_cyc + WR_GAP + 1)
                            fail("wr_gap", $sformatf("got read at %0d, want >= %0d", cyc, last_w_cyc + WR_GAP + 1));
                    end
                end
                if (we) begin
                    have_w = 1;
                    last_w_cyc = cyc;
                    last_w_addr = waddr;
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                checks++;
                if (exp_rsp.size() == 0 || rd_iss_cyc.size() == 0) begin
                    fail("rsp_unexpected", $sformatf("got rsp addr=%h, want no rsp", rsp_addr));
                end else begin
                    m_r = exp_rsp.pop_front();
                    m_ic = rd_iss_cyc.pop_front();
                    if (rsp_addr !== m_r.a || rsp_data !== m_r.d)
                        fail("rsp", $sformatf("got addr=%h data=%h, want addr=%h data=%h",
                             rsp_addr, rsp_data, m_r.a, m_r.d));
                    checks++;
                    if (cyc - m_ic != RD_LAT)
                        fail("rsp_latency", $sformatf("got %0d, want %0d", cyc - m_ic, RD_LAT));
                end
            end
        end
    end

    task automatic push(input logic w, input logic [9:0] a, input logic [63:0] d,
                        input int rel, input bit chk_ready);
        int waited;
        iss_t e;
        rsp_t r;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (chk_ready) begin
            checks++;
            if (cmd_ready !== 1'b1)
                fail("ready_held", $sformatf("got cmd_ready=%b, want 1", cmd_ready));
        end
        while (cmd_ready !== 1'b1) begin
            if (waited >= 200) begin
                checks++;
                fail("push_timeout", "got cmd_ready stuck 0, want 1 within 200 cycles");
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        e.w = w;
        e.a = a;
        e.d = d;
        e.exp_cyc = (rel < 0) ? -1 : cyc + rel;
        exp_iss.push_back(e);
        if (w) begin
            mem_ref[a] = d;
        end else begin
            r.a = a;
            r.d = mem_ref[a];
            exp_rsp.push_back(r);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (cmd_ready !== 1'b1 || we !== 1'b0 || re !== 1'b0 || waddr !== 10'd0 ||
            raddr !== 10'd0 || data_in !== 64'd0 || rsp_valid !== 1'b0 || rsp_addr !== 10'd0)
            fail(name, $sformatf("got ready=%b we=%b re=%b waddr=%h raddr=%h data=%h rv=%b ra=%h, want 1 0 0 0 0 0 0 0",
                 cmd_ready, we, re, waddr, raddr, data_in, rsp_valid, rsp_addr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        int rsp_before;
        for (int a = 0; a < 1024; a++) begin
            mem_tb[a]  = init_val(a);
            mem_ref[a] = init_val(a);
        end
        for (int i = 0; i < RD_LAT; i++) rdq[i] = '0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        idle(3);
        @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b1;
        idle(2);

        // single write, then read of the same word
        push(1'b1, 10'h005, 64'hDEAD_BEEF_0000_0001, 2, 1'b1);
        idle(6);
        push(1'b0, 10'h005, 64'h0, 2, 1'b1);
        idle(6);

        // write then read same address: two bubbles; different address: none
        push(1'b1, 10'h010, 64'hA5A5_0000_0000_0010, 2, 1'b1);
        push(1'b0, 10'h010, 64'h0, 4, 1'b0);
        idle(8);
        push(1'b1, 10'h010, 64'hA5A5_0000_0000_0011, 2, 1'b1);
        push(1'b0, 10'h011, 64'h0, 2, 1'b1);
        idle(8);

        // six back-to-back commands, no stalls, ready never drops
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                push(1'b1, 10'(10'h100 + i), {32'hB0B0_0000, 32'(i)}, 2, 1'b1);
            else
                push(1'b0, 10'(10'h080 + i), 64'h0, 2, 1'b1);
        end
        idle(8);

        // forced hazards fill the FIFO, then it drains
        saw_full = 0;
        for (int i = 0; i < 8; i++)
            push(i[0] == 1'b0, 10'h020, {32'hF111_0000, 32'(i)}, -1, 1'b0);
        idle(30);
        checks++;
        if (!saw_full) fail("fifo_full", "got cmd_ready never 0, want 0 at count=DEPTH");
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) fail("ready_recover", $sformatf("got %b, want 1", cmd_ready));

        // pointer wrap with alternating write/read to distinct addresses
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                push(1'b1, 10'(10'h200 + i), {32'hCAFE_0000, 32'(i)}, 2, 1'b0);
            else
                push(1'b0, 10'(10'h300 + i), 64'h0, 2, 1'b0);
        end
        idle(8);

        // randomized traffic over a small address set to provoke hazards
        for (int i = 0; i < 300; i++) begin
            push(1'($urandom_range(0, 1)), 10'(10'h380 + $urandom_range(0, 7)),
                 {$urandom, $urandom}, -1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(40);

        // reset with reads in flight and commands queued
        push(1'b1, 10'h040, 64'h7777_0000_0000_0040, 2, 1'b0);
        push(1'b0, 10'h040, 64'h0, 4, 1'b0);
        for (int i = 1; i <= 4; i++)
            push(1'b0, 10'(10'h040 + i), 64'h0, -1, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            #2;
            if (re === 1'b1 && raddr === 10'h041) found = 1;
        end
        checks++;
        if (found == 0) fail("reset_setup", "got no read of 0x041, want one within 20 cycles");
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        exp_iss.delete();
        exp_rsp.delete();
        rd_iss_cyc.delete();
        have_w = 0;
        rsp_before = rsp_seen;
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        checks++;
        if (rsp_seen != rsp_before)
            fail("no_rsp_after_reset", $sformatf("got %0d strobes, want 0", rsp_seen - rsp_before));

        // FIFO usable again after reset
        push(1'b1, 10'h005, 64'h0123_4567_89AB_CDEF, 2, 1'b1);
        push(1'b0, 10'h006, 64'h0, 2, 1'b1);
        idle(10);

        checks++;
        if (exp_iss.size() != 0)
            fail("issue_drain", $sformatf("got %0d pending issues, want 0", exp_iss.size()));
        checks++;
        if (exp_rsp.size() != 0)
            fail("rsp_drain", $sformatf("got %0d pending responses, want 0", exp_rsp.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
